// File: rtl/lfsr_rng_arbiter_pkg.sv
// Shared types and constants for the LFSR random-number server.
// Taps describe the 16-bit Fibonacci polynomial x^16+x^14+x^13+x^11+1.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_rng_arbiter_rr.sv
// Round-robin picker: first asserted request searching upward from last+1,
// wrapping, so the most recently served requester has the lowest priority.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NREQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Random-number server: one Fibonacci LFSR, a fresh WORD_W-bit word per grant,
// round-robin shared between NREQ requesters. Seed may be reloaded while idle.
module lfsr_rng_arbiter
  import lfsr_pkg::*;
#(
  parameter int                NREQ   = 4,
  parameter int                LFSR_W = 16,
  parameter int                WORD_W = 8,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   ack,
  output logic [WORD_W-1:0] rdata,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              busy,
  output state_e            dbg_state,
  output logic [LFSR_W-1:0] dbg_lfsr
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(WORD_W) + 1;

  // Handshake: a requester holds req[i] high until it sees ack[i], a one-cycle
  // pulse during which rdata carries its word; it must drop req the next cycle.

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  r_q, r_d;
  logic [WORD_W-1:0]  w_q, w_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [WORD_W-1:0]  rdata_q, rdata_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [NREQ-1:0]    arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               fb;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .req   (req),
    .last  (last_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    w_d         = w_q;
    cnt_d       = cnt_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    last_d      = last_q;
    rdata_d     = rdata_q;
    ack_d       = '0;
    fb          = r_q[TAP_A] ^ r_q[TAP_B] ^ r_q[TAP_C] ^ r_q[TAP_D];
    case (state_q)
      ST_IDLE: begin
        // A zero seed would lock the LFSR, so it falls back to SEED.
        if (seed_load) begin
          r_d = (seed == '0) ? SEED : seed;
        end else if (|req) begin
          grant_oh_d  = arb_grant;
          grant_idx_d = arb_idx;
          cnt_d       = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        r_d   = {r_q[LFSR_W-2:0], fb};
        w_d   = WORD_W'({w_q, fb});
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WORD_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        rdata_d = w_q;
        ack_d   = grant_oh_q;
        last_d  = grant_idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      r_q         <= SEED;
      w_q         <= '0;
      cnt_q       <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
      last_q      <= IDX_W'(NREQ - 1);
      rdata_q     <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      w_q         <= w_d;
      cnt_q       <= cnt_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
      last_q      <= last_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign dbg_lfsr  = r_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: directed and randomized transactions checked
// against a word-level model of the generator and the round-robin rule.
module tb_lfsr_rng_arbiter;
  import lfsr_pkg::*;

  localparam logic [15:0] RST_SEED = 16'hACE1;
  localparam logic [15:0] TAP_MASK = 16'hB400;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic        seed_load;
  logic [15:0] seed;
  logic        busy;
  state_e      dbg_state;
  logic [15:0] dbg_lfsr;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] m_lfsr;
  int          m_last;
  logic [7:0]  last_word;

  lfsr_rng_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .ack       (ack),
    .rdata     (rdata),
    .seed_load (seed_load),
    .seed      (seed),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_lfsr  (dbg_lfsr)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // reference model: word = next 8 feedback bits, feedback = parity of taps
  task automatic model_next(output logic [7:0] wd);
    int acc = 0;
    for (int k = 0; k < 8; k++) begin
      int b = $countones(m_lfsr & TAP_MASK) % 2;
      acc = acc * 2 + b;
      m_lfsr = 16'((int'(m_lfsr) * 2 + b) % 65536);
    end
    wd = 8'(acc);
  endtask

  function automatic int model_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_lfsr = RST_SEED;
    m_last = 3;
    last_word = 8'h00;
  endtask

  // driver tasks
  task automatic load_seed(input logic [15:0] v);
    @(negedge clock);
    seed_load = 1'b1;
    seed = v;
    @(posedge clock); #1;
    seed_load = 1'b0;
    m_lfsr = (v == 16'h0) ? RST_SEED : v;
    chk("seed_lfsr", 32'(dbg_lfsr), 32'(m_lfsr));
    chk("seed_busy", 32'(busy), 32'(0));
  endtask

  task automatic do_txn(input logic [3:0] r, input int exp_lat, input bit sd_now,
                        input logic [15:0] sd_val, input int drop_at, input int pulse_at);
    int lat;
    int exp_idx;
    logic [7:0] wd;
    @(negedge clock);
    req = r;
    if (sd_now) begin
      seed_load = 1'b1;
      seed = sd_val;
      m_lfsr = (sd_val == 16'h0) ? RST_SEED : sd_val;
    end
    exp_idx = model_pick(r, m_last);
    model_next(wd);
    exp_q.push_back(wd);
    lat = 0;
    while (1) begin
      @(posedge clock); #1;
      lat++;
      seed_load = (lat == pulse_at);
      if (lat == pulse_at) seed = 16'($urandom);
      if (lat == 2) chk("busy_shift", 32'(busy), 32'(1));
      if (lat == drop_at) req = '0;
      if (ack !== '0 || lat >= 40) break;
    end
    seed_load = 1'b0;
    chk("txn_latency", 32'(lat), 32'(exp_lat));
    chk("txn_ack", 32'(ack), 32'(4'b0001 << exp_idx));
    chk("txn_rdata", 32'(rdata), 32'(exp_q.pop_front()));
    chk("txn_lfsr", 32'(dbg_lfsr), 32'(m_lfsr));
    chk("txn_busy", 32'(busy), 32'(0));
    m_last = exp_idx;
    last_word = wd;
    req = '0;
  endtask

  initial begin
    int lat;
    int exp_idx;
    logic [7:0] wd;
    logic [3:0] r;
    logic [15:0] sv;
    int drop;
    int pulse;

    reset = 1'b1;
    req = '0;
    seed_load = 1'b0;
    seed = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_lfsr", 32'(dbg_lfsr), 32'(16'hACE1));
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // known-answer words from seed 0x0001
    load_seed(16'h0001);
    do_txn(4'b0001, 10, 1'b0, 16'h0, 0, 0);
    chk("kat1_rdata", 32'(rdata), 32'(8'h00));
    chk("kat1_lfsr", 32'(dbg_lfsr), 32'(16'h0100));
    do_txn(4'b0001, 10, 1'b0, 16'h0, 0, 0);
    chk("kat2_rdata", 32'(rdata), 32'(8'h2D));
    chk("kat2_lfsr", 32'(dbg_lfsr), 32'(16'h002D));

    // zero seed substitutes the default; seed_load during SHIFT is ignored
    load_seed(16'h0000);
    chk("zero_seed", 32'(dbg_lfsr), 32'(16'hACE1));
    do_txn(4'b0010, 10, 1'b0, 16'h0, 0, 5);

    // seed_load and req in the same idle cycle: seed first, grant a cycle later
    do_txn(4'b0100, 11, 1'b1, 16'h1234, 0, 0);
    chk("seed_req_ack", 32'(ack), 32'(4'b0100));

    repeat (5) @(posedge clock);
    #1;
    chk("rdata_hold", 32'(rdata), 32'(last_word));
    chk("ack_idle", 32'(ack), 32'(0));

    // reset during the 4th SHIFT cycle
    @(negedge clock);
    req = 4'b0001;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ack", 32'(ack), 32'(0));
    chk("midrst_rdata", 32'(rdata), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_lfsr", 32'(dbg_lfsr), 32'(16'hACE1));
    // requests held across reset release: all four served in turn
    req = 4'b1111;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      exp_idx = model_pick(4'b1111, m_last);
      model_next(wd);
      lat = 0;
      do begin
        @(posedge clock); #1;
        lat++;
        if (lat < 10) chk("rr_no_early_ack", 32'(ack), 32'(0));
      end while (ack === '0 && lat < 40);
      chk("rr_spacing", 32'(lat), 32'(10));
      chk("rr_ack", 32'(ack), 32'(4'b0001 << exp_idx));
      chk("rr_rdata", 32'(rdata), 32'(wd));
      m_last = exp_idx;
      last_word = wd;
    end
    req = '0;

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      r = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) begin
        sv = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        load_seed(sv);
      end
      drop  = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 9) : 0;
      pulse = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 8) : 0;
      do_txn(r, 10, 1'b0, 16'h0, drop, pulse);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
